riscv_imem_fetch: RTL and testbench
===================================

# riscv_imem_fetch

Instruction-memory fetch controller between the core's instruction fetch port (`if_nxt_pc` / `if_parcel*`) and a pipelined, in-order instruction bus.
- Accepts fetch addresses from the core and issues aligned word requests.
- Keeps up to DEPTH fetches in flight or buffered, and returns parcels to the core in program order.
- Discards responses belonging to flushed fetches.

## Interface
- `XLEN`, 32, address/data width
- `PARCEL_SIZE`, 32, parcel width; equals XLEN
- `DEPTH`, 4, completion-buffer entries; power of two, ≥2
- `PC_INIT`, 'h200, `if_parcel_pc` reset value
- `clk` in 1 — single clock, rising edge
- `rstn` in 1 — reset, asynchronous, active-low
- `if_nxt_pc` in XLEN — next fetch address from core
- `if_stall_nxt_pc` out 1 — high: `if_nxt_pc` not accepted this cycle
- `if_stall` in 1 — core holds current parcel
- `if_flush` in 1 — discard all pending fetches
- `if_parcel` out PARCEL_SIZE — instruction data
- `if_parcel_pc` out XLEN — address of `if_parcel`
- `if_parcel_valid` out 1 — parcel/fault flags valid
- `if_parcel_misaligned` out 1 — fetch address not word aligned
- `if_parcel_page_fault` out 1 — bus error on this fetch; the core has no separate access-fault input
- `mem_req` out 1 — bus request
- `mem_adr` out XLEN — request address, equals `if_nxt_pc`
- `mem_gnt` in 1 — request accepted this cycle
- `mem_ack` in 1 — in-order response valid
- `mem_q` in XLEN — response data
- `mem_err` in 1 — response is a bus error; qualified by `mem_ack`

## Operation
**Occupancy**
- occ = buffered entries + discard count.
- can_issue = rstn & !if_flush & (occ < DEPTH), with occ taken after this cycle's pop.

**Issue**
- Aligned address (`if_nxt_pc[1:0]==0`):
  - `mem_req` = can_issue.
  - Accept = `mem_req & mem_gnt`.
  - On accept, push entry {pc, misaligned=0, filled=0}.
- Misaligned address:
  - `mem_req` stays 0.
  - Accept = can_issue.
  - On accept, push entry {pc, misaligned=1, filled=1, data=0}.
- `if_stall_nxt_pc` = !accept.

**Completion**
- `mem_ack` with discard==0: write `mem_q` and `mem_err` into the oldest unfilled entry and set filled.
- `mem_ack` with discard>0: decrement discard; no entry is written.
- `mem_ack` with no outstanding request is a protocol error; the bench asserts on it.

**Output**
- Head entry drives `if_parcel*`.
- `if_parcel_valid` = head.filled & !if_flush.
- Pop = valid & !`if_stall`.

**Flush** (one-cycle pulse, highest priority)
- All entries are invalidated and pointers reset.
- discard ← outstanding (issued, unacked) minus any same-cycle discard-bound ack.
- A same-cycle ack is counted as discarded, never written.
- No accept and no pop occur in the flush cycle.

**Simultaneous events**
- Push and pop in the same cycle when full are legal; the occupancy check uses the post-pop value.
- Push and fill may target the same entry only when it is misaligned (already filled); no conflict.

**Reset**
- `rstn` low mid-operation clears all state; discard=0.
- Late acks arriving after reset release are a system-level error (the bus is reset together with the block).

## Timing
- Aligned fetch, accept in cycle N:
  - earliest `mem_ack` N+1;
  - entry filled at the end of the ack cycle;
  - `if_parcel_valid` is high from N+2 at the earliest.
- Misaligned fetch: valid in N+1.
- Back-to-back throughput: one parcel per cycle when `mem_gnt`/`mem_ack` are continuously high and DEPTH≥2.
- `if_parcel*` are register outputs; they are gated combinationally only by `if_flush`.
- `mem_req`, `mem_adr` and `if_stall_nxt_pc` are combinational from `if_nxt_pc`, `mem_gnt`, `if_flush` and registered state.
- Reset values:
  - `mem_req` 0;
  - `if_stall_nxt_pc` 1;
  - `if_parcel_valid` 0;
  - `if_parcel` 0;
  - `if_parcel_pc` PC_INIT;
  - `if_parcel_misaligned` 0;
  - `if_parcel_page_fault` 0;
  - pointers and discard 0.

## Structure
- Add `fetch_entry_t` {pc, data, misaligned, err, filled} to `riscv_rv12_pkg`.
- Local parameter `PTR_BITS=$clog2(DEPTH)`; discard counter is PTR_BITS+1 bits.
- One sub-module, `riscv_imem_queue`, owns the pointer/count logic:
  - push ptr, fill ptr, pop ptr;
  - each pointer is PTR_BITS+1 bits with a wrap bit for full/empty detection;
  - flush clear.
- The top level owns issue, discard and output gating.

## Test plan
1. **Streaming fetch:** `if_nxt_pc` 0x200, 0x204, 0x208 accepted in cycles 1-3; ack data 0xA, 0xB, 0xC in cycles 2-4 → parcels {0x200:0xA}, {0x204:0xB}, {0x208:0xC} valid in cycles 3-5.
2. **Full and stall:** DEPTH=4, `if_stall`=1, `mem_gnt`/`mem_ack` always 1 → 4 accepts, then `if_stall_nxt_pc`=1 and `mem_req`=0. Release `if_stall` → one accept per pop, no parcel loss.
3. **Flush with 2 outstanding:** pulse `if_flush`; the next 2 acks (data 0xDEAD) are discarded. New fetch 0x300 accepted after the flush; its ack 0x13 → parcel {0x300:0x13}, never 0xDEAD.
4. **Flush coincident with ack:** 3 outstanding, flush and ack in the same cycle → discard=2; the 3rd subsequent ack is delivered for the post-flush fetch.
5. **Misaligned fetch:** 0x202 → no `mem_req`; next cycle valid with `if_parcel_misaligned`=1 and `if_parcel_pc`=0x202, in order behind earlier aligned fetches.
6. **Bus error and reset:** ack with `mem_err`=1 → `if_parcel_page_fault`=1 for that pc only. Asserting `rstn`=0 mid-stream → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/riscv_rv12_pkg.sv
// Shared RV12 fetch-path types: one completion-buffer entry and an alignment helper.
package riscv_rv12_pkg;

  localparam int FETCH_XLEN = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] data;
    logic                  misaligned;
    logic                  err;
    logic                  filled;
  } fetch_entry_t;

  function automatic logic word_aligned(input logic [FETCH_XLEN-1:0] adr);
    return adr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/riscv_imem_queue.sv
// Pointer bookkeeping for the fetch completion buffer: push, fill and pop pointers
// with a wrap bit each, plus lookup of the oldest entry still waiting for bus data.
module riscv_imem_queue
  import riscv_rv12_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                push,
  input  logic                fill,
  input  logic                pop,
  input  logic [DEPTH-1:0]    filled_vec,
  output logic [PTR_BITS-1:0] push_idx,
  output logic [PTR_BITS-1:0] fill_idx,
  output logic [PTR_BITS-1:0] pop_idx,
  output logic                fill_found,
  output logic [PTR_BITS:0]   count,
  output logic                empty
);

  localparam int PW = PTR_BITS + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] push_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] pop_ptr;
  logic [PW-1:0] fill_span;
  logic [PW-1:0] fill_sel;
  logic [PW-1:0] cand;

  assign push_idx = push_ptr[PTR_BITS-1:0];
  assign pop_idx  = pop_ptr[PTR_BITS-1:0];
  assign fill_idx = fill_sel[PTR_BITS-1:0];
  assign count    = push_ptr - pop_ptr;
  assign empty    = (push_ptr == pop_ptr);

  // Misaligned entries are born filled, so the fill pointer may sit on entries
  // that need no data; skip forward to the first one that really is unfilled.
  always_comb begin
    fill_span  = push_ptr - fill_ptr;
    fill_found = 1'b0;
    fill_sel   = fill_ptr;
    cand       = fill_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      cand = fill_ptr + PW'(i);
      if (!fill_found && (PW'(i) < fill_span) && !filled_vec[cand[PTR_BITS-1:0]]) begin
        fill_found = 1'b1;
        fill_sel   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      push_ptr <= '0;
      fill_ptr <= '0;
      pop_ptr  <= '0;
    end else if (flush) begin
      push_ptr <= '0;
      fill_ptr <= '0;
      pop_ptr  <= '0;
    end else begin
      if (push) begin
        push_ptr <= push_ptr + PTR_ONE;
      end
      // Keep the fill pointer from falling behind the head when a pre-filled entry pops.
      if (fill && fill_found) begin
        fill_ptr <= fill_sel + PTR_ONE;
      end else if (pop && (pop_ptr == fill_ptr)) begin
        fill_ptr <= fill_ptr + PTR_ONE;
      end
      if (pop) begin
        pop_ptr <= pop_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/riscv_imem_fetch.sv
// Instruction fetch controller: issues word requests on a pipelined in-order bus,
// buffers up to DEPTH fetches and returns parcels in program order, dropping flushed ones.
module riscv_imem_fetch
  import riscv_rv12_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter int               PARCEL_SIZE = 32,
  parameter int               DEPTH       = 4,
  parameter logic [XLEN-1:0]  PC_INIT     = 'h200
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [XLEN-1:0]        if_nxt_pc,
  output logic                   if_stall_nxt_pc,
  input  logic                   if_stall,
  input  logic                   if_flush,
  output logic [PARCEL_SIZE-1:0] if_parcel,
  output logic [XLEN-1:0]        if_parcel_pc,
  output logic                   if_parcel_valid,
  output logic                   if_parcel_misaligned,
  output logic                   if_parcel_page_fault,
  output logic                   mem_req,
  output logic [XLEN-1:0]        mem_adr,
  input  logic                   mem_gnt,
  input  logic                   mem_ack,
  input  logic [XLEN-1:0]        mem_q,
  input  logic                   mem_err
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CW       = PTR_BITS + 1;
  localparam int OW       = PTR_BITS + 2;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  fetch_entry_t        entries [DEPTH];
  fetch_entry_t        head;
  logic [DEPTH-1:0]    filled_vec;
  logic [PTR_BITS-1:0] push_idx;
  logic [PTR_BITS-1:0] fill_idx;
  logic [PTR_BITS-1:0] pop_idx;
  logic                fill_found;
  logic                empty;
  logic [CW-1:0]       count;
  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       discard;
  logic [CW-1:0]       issue_inc;
  logic [CW-1:0]       ack_dec;
  logic [OW-1:0]       occ;
  logic                aligned;
  logic                can_issue;
  logic                accept;
  logic                valid;
  logic                pop;
  logic                ack_valid;
  logic                ack_discard;
  logic                fill_en;

  always_comb begin
    filled_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_vec[i] = entries[i].filled;
    end
  end

  assign head    = entries[pop_idx];
  assign aligned = word_aligned(if_nxt_pc);
  assign valid   = !empty && head.filled && !if_flush;
  assign pop     = valid && !if_stall;

  // Occupancy counts flushed-but-unacked requests too, so a slot is only reused once
  // the bus can no longer return stale data into it.
  assign occ       = OW'(count) - OW'(pop) + OW'(discard);
  assign can_issue = rstn && !if_flush && (occ < OW'(DEPTH));

  assign mem_req         = aligned && can_issue;
  assign mem_adr         = if_nxt_pc;
  assign accept          = aligned ? (mem_req && mem_gnt) : can_issue;
  assign if_stall_nxt_pc = !accept;

  assign ack_valid   = mem_ack && (outstanding != '0);
  assign ack_discard = ack_valid && (discard != '0);
  assign fill_en     = ack_valid && !if_flush && (discard == '0) && fill_found;
  assign issue_inc   = CW'(accept && aligned);
  assign ack_dec     = CW'(ack_valid);

  riscv_imem_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (if_flush),
    .push       (accept),
    .fill       (fill_en),
    .pop        (pop),
    .filled_vec (filled_vec),
    .push_idx   (push_idx),
    .fill_idx   (fill_idx),
    .pop_idx    (pop_idx),
    .fill_found (fill_found),
    .count      (count),
    .empty      (empty)
  );

  // On flush every request still on the bus becomes discard-bound, including the
  // one whose ack lands in the flush cycle itself.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outstanding <= '0;
      discard     <= '0;
    end else if (if_flush) begin
      outstanding <= outstanding - ack_dec;
      discard     <= outstanding - ack_dec;
    end else begin
      outstanding <= outstanding + issue_inc - ack_dec;
      if (ack_discard) begin
        discard <= discard - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '{pc: PC_INIT, data: '0, misaligned: 1'b0, err: 1'b0, filled: 1'b0};
      end
    end else if (if_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].filled <= 1'b0;
      end
    end else begin
      if (accept) begin
        entries[push_idx] <= '{pc: if_nxt_pc, data: '0, misaligned: !aligned,
                               err: 1'b0, filled: !aligned};
      end
      if (fill_en) begin
        entries[fill_idx].data   <= mem_q;
        entries[fill_idx].err    <= mem_err;
        entries[fill_idx].filled <= 1'b1;
      end
    end
  end

  assign if_parcel            = head.data;
  assign if_parcel_pc         = head.pc;
  assign if_parcel_valid      = valid;
  assign if_parcel_misaligned = head.misaligned;
  assign if_parcel_page_fault = head.err;

endmodule

// File: tb/tb_riscv_imem_fetch.sv
// Randomized scoreboard bench for riscv_imem_fetch: the bench plays the bus and the core,
// predicts acceptance from buffer occupancy, and a monitor checks every consumed parcel.
module tb_riscv_imem_fetch;

  localparam int          XLEN    = 32;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] PC_INIT = 32'h200;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] if_nxt_pc = '0;
  logic        if_stall_nxt_pc;
  logic        if_stall = 1'b0;
  logic        if_flush = 1'b0;
  logic [31:0] if_parcel;
  logic [31:0] if_parcel_pc;
  logic        if_parcel_valid;
  logic        if_parcel_misaligned;
  logic        if_parcel_page_fault;
  logic        mem_req;
  logic [31:0] mem_adr;
  logic        mem_gnt = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_q = '0;
  logic        mem_err = 1'b0;

  always #5 clk = ~clk;

  riscv_imem_fetch #(
    .XLEN        (XLEN),
    .PARCEL_SIZE (XLEN),
    .DEPTH       (DEPTH),
    .PC_INIT     (PC_INIT)
  ) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .if_nxt_pc            (if_nxt_pc),
    .if_stall_nxt_pc      (if_stall_nxt_pc),
    .if_stall             (if_stall),
    .if_flush             (if_flush),
    .if_parcel            (if_parcel),
    .if_parcel_pc         (if_parcel_pc),
    .if_parcel_valid      (if_parcel_valid),
    .if_parcel_misaligned (if_parcel_misaligned),
    .if_parcel_page_fault (if_parcel_page_fault),
    .mem_req              (mem_req),
    .mem_adr              (mem_adr),
    .mem_gnt              (mem_gnt),
    .mem_ack              (mem_ack),
    .mem_q                (mem_q),
    .mem_err              (mem_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        mis;
    logic        err;
    logic        filled;
  } ent_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } bus_t;

  // Model: fetches held by the controller, requests pending on the bus, discard count.
  ent_t fetch_q[$];
  ent_t sb_q[$];
  bus_t bus_q[$];
  int   discard = 0;
  int   errors  = 0;
  int   checks  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idleInputs();
    if_nxt_pc = 32'h0;
    mem_gnt   = 1'b0;
    mem_ack   = 1'b0;
    mem_q     = 32'h0;
    mem_err   = 1'b0;
    if_stall  = 1'b0;
    if_flush  = 1'b0;
  endtask

  task automatic checkReset();
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_stall_nxt_pc", 32'(if_stall_nxt_pc), 32'd1);
    checkOutput("rst_valid", 32'(if_parcel_valid), 32'd0);
    checkOutput("rst_parcel", if_parcel, 32'd0);
    checkOutput("rst_parcel_pc", if_parcel_pc, PC_INIT);
    checkOutput("rst_misaligned", 32'(if_parcel_misaligned), 32'd0);
    checkOutput("rst_page_fault", 32'(if_parcel_page_fault), 32'd0);
  endtask

  task automatic midReset();
    @(negedge clk);
    rstn = 1'b0;
    idleInputs();
    #1;
    checkReset();
    fetch_q.delete();
    sb_q.delete();
    bus_q.delete();
    discard = 0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // One core/bus cycle: drive random inputs, check the combinational handshake
  // against the occupancy rules, then advance the model to the next cycle.
  task automatic applyStimulus(input int p_gnt, input int p_ack, input int p_stall,
                               input int p_flush, input int p_mis);
    logic [31:0] pc;
    logic        do_flush, do_ack, aligned, exp_valid, do_pop, can, exp_req, acc, found;
    int          occ;
    ent_t        e;
    bus_t        nb;
    @(negedge clk);
    do_flush = ($urandom_range(0, 99) < p_flush);
    do_ack   = (bus_q.size() > 0) && ($urandom_range(0, 99) < p_ack);
    pc = $urandom_range(0, 1023) << 2;
    if ($urandom_range(0, 99) < p_mis) pc = pc | $urandom_range(1, 3);
    if_nxt_pc = pc;
    if_flush  = do_flush;
    if_stall  = ($urandom_range(0, 99) < p_stall);
    mem_gnt   = ($urandom_range(0, 99) < p_gnt);
    mem_ack   = do_ack;
    if (do_ack) begin
      mem_q   = bus_q[0].data;
      mem_err = bus_q[0].err;
    end else begin
      mem_q   = $urandom;
      mem_err = 1'($urandom_range(0, 1));
    end
    #1;
    exp_valid = (fetch_q.size() > 0) && fetch_q[0].filled && !do_flush;
    do_pop    = exp_valid && !if_stall;
    occ       = fetch_q.size() - (do_pop ? 1 : 0) + discard;
    can       = !do_flush && (occ < DEPTH);
    aligned   = (pc[1:0] == 2'b00);
    exp_req   = aligned && can;
    acc       = aligned ? (exp_req && mem_gnt) : can;
    checkOutput("mem_req", 32'(mem_req), 32'(exp_req));
    checkOutput("stall_nxt_pc", 32'(if_stall_nxt_pc), 32'(!acc));
    checkOutput("parcel_valid", 32'(if_parcel_valid), 32'(exp_valid));
    if (exp_req) checkOutput("mem_adr", mem_adr, pc);
    if (do_flush) begin
      fetch_q.delete();
      sb_q.delete();
      if (do_ack) void'(bus_q.pop_front());
      discard = bus_q.size();
    end else begin
      if (do_ack) begin
        void'(bus_q.pop_front());
        if (discard > 0) begin
          discard--;
        end else begin
          found = 1'b0;
          foreach (fetch_q[i]) begin
            if (!found && !fetch_q[i].filled) begin
              fetch_q[i].filled = 1'b1;
              found = 1'b1;
            end
          end
        end
      end
      if (do_pop) void'(fetch_q.pop_front());
      if (acc) begin
        if (aligned) begin
          nb.data = $urandom;
          nb.err  = ($urandom_range(0, 7) == 0);
          bus_q.push_back(nb);
          e = '{pc: pc, data: nb.data, mis: 1'b0, err: nb.err, filled: 1'b0};
        end else begin
          e = '{pc: pc, data: 32'h0, mis: 1'b1, err: 1'b0, filled: 1'b1};
        end
        fetch_q.push_back(e);
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic runPhase(input int n, input int p_gnt, input int p_ack, input int p_stall,
                          input int p_flush, input int p_mis);
    for (int k = 0; k < n; k++) begin
      applyStimulus(p_gnt, p_ack, p_stall, p_flush, p_mis);
    end
  endtask

  // Monitor: every parcel the core consumes must be the oldest expected one.
  initial begin
    ent_t exp;
    forever begin
      @(negedge clk);
      #2;
      if (rstn && if_parcel_valid && !if_stall) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_underflow: got parcel pc %h expected no parcel", if_parcel_pc);
        end else begin
          exp = sb_q.pop_front();
          checkOutput("parcel_pc", if_parcel_pc, exp.pc);
          checkOutput("parcel_data", if_parcel, exp.data);
          checkOutput("parcel_misaligned", 32'(if_parcel_misaligned), 32'(exp.mis));
          checkOutput("parcel_page_fault", 32'(if_parcel_page_fault), 32'(exp.err));
        end
      end
    end
  end

  initial begin
    idleInputs();
    rstn = 1'b0;
    @(negedge clk);
    #1;
    checkReset();
    @(negedge clk);
    rstn = 1'b1;
    runPhase(40, 100, 100, 0, 0, 0);
    runPhase(60, 100, 100, 80, 0, 0);
    runPhase(100, 70, 60, 30, 8, 15);
    runPhase(100, 50, 50, 40, 15, 25);
    midReset();
    runPhase(100, 80, 80, 20, 5, 10);
    runPhase(30, 0, 100, 0, 0, 0);
    @(negedge clk);
    #3;
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
